// File: rtl/sched_input_queue_pkg.sv
// Shared constants and helpers for the scheduler input path.
package sched_input_queue_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_N_INPUTS   = 4;
  localparam int unsigned DEF_DEPTH      = 4;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned PTR_W = ptr_width(DEF_DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEF_DEPTH);

  // Low bit of lane `lane` in a packed multi-lane bus.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/sched_input_queue_lane_fifo.sv
// Single-lane show-ahead FIFO; head word, valid and full are all registered.
module lane_fifo
  import sched_input_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  full,
  output logic                  ovf
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic                  do_push, do_pop, ovf_nxt;

  // Next-state: a full lane still accepts a push when it is popped the same cycle.
  always_comb begin
    do_pop   = pop && (cnt != '0);
    do_push  = push && (!full || pop);
    cnt_nxt  = cnt;
    wr_nxt   = wr_ptr;
    rd_nxt   = rd_ptr;
    ovf_nxt  = ovf | (push & ~do_push);
    head_nxt = '0;
    if (do_push && !do_pop) begin
      cnt_nxt = cnt + CW'(1);
    end else if (!do_push && do_pop) begin
      cnt_nxt = cnt - CW'(1);
    end
    if (do_push) begin
      wr_nxt = wr_ptr + PW'(1);
    end
    if (do_pop) begin
      rd_nxt = rd_ptr + PW'(1);
    end
    // The new head is the incoming word when it lands on the next read slot.
    if (cnt_nxt == '0) begin
      head_nxt = '0;
    end else if (do_push && (rd_nxt == wr_ptr)) begin
      head_nxt = din;
    end else begin
      head_nxt = mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      dout   <= head_nxt;
      valid  <= (cnt_nxt != '0);
      full   <= (cnt_nxt == CW'(DEPTH));
      ovf    <= ovf_nxt;
    end
  end

  // Storage is not reset; it is only observable through the registered head.
  always_ff @(posedge clk) begin
    if (rst && do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/sched_input_queue.sv
// Per-lane input FIFOs feeding the scheduler; top level only packs the lane buses.
module sched_input_queue
  import sched_input_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned N_INPUTS   = DEF_N_INPUTS,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_INPUTS-1:0]            push,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] data_in,
  input  logic [N_INPUTS-1:0]            pop,
  output logic [N_INPUTS*DATA_WIDTH-1:0] r_out,
  output logic [N_INPUTS-1:0]            valid,
  output logic [N_INPUTS-1:0]            full,
  output logic [N_INPUTS-1:0]            ovf
);

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_lane
    lane_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .din   (data_in[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH]),
      .pop   (pop[i]),
      .dout  (r_out[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH]),
      .valid (valid[i]),
      .full  (full[i]),
      .ovf   (ovf[i])
    );
  end

endmodule

// File: tb/tb_sched_input_queue.sv
// Directed and random stimulus for sched_input_queue against a queue-based reference model.
module tb_sched_input_queue;
  import sched_input_queue_pkg::*;

  localparam int unsigned DW = DEF_DATA_WIDTH;
  localparam int unsigned NI = DEF_N_INPUTS;
  localparam int unsigned DP = DEF_DEPTH;

  logic           clk = 1'b0;
  logic           rst;
  logic [NI-1:0]  push, pop;
  logic [NI*DW-1:0] data_in, r_out;
  logic [NI-1:0]  valid, full, ovf;

  logic [DW-1:0] mq [NI][$];
  logic [NI-1:0] movf;
  logic [DW-1:0] seen [$];
  int n_checks = 0;
  int n_err    = 0;

  sched_input_queue dut (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .data_in (data_in),
    .pop     (pop),
    .r_out   (r_out),
    .valid   (valid),
    .full    (full),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: each lane is a bounded queue; a push into a full lane only succeeds alongside a pop.
  task automatic model_edge(input logic r, input logic [NI-1:0] pu, input logic [NI-1:0] po,
                            input logic [NI*DW-1:0] d);
    for (int i = 0; i < NI; i++) begin
      if (!r) begin
        mq[i].delete();
        movf[i] = 1'b0;
      end else begin
        int sz;
        sz = mq[i].size();
        if (po[i] && sz > 0) void'(mq[i].pop_front());
        if (pu[i]) begin
          if (sz < int'(DP) || (po[i] && sz > 0)) mq[i].push_back(d[i*DW +: DW]);
          else movf[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [NI*DW-1:0] er;
    logic [NI-1:0] ev, ef;
    er = '0; ev = '0; ef = '0;
    for (int i = 0; i < NI; i++) begin
      if (mq[i].size() > 0) begin
        er[i*DW +: DW] = mq[i][0];
        ev[i] = 1'b1;
      end
      ef[i] = (mq[i].size() == int'(DP));
    end
    check({tag, ".r_out"}, 64'(r_out), 64'(er));
    check({tag, ".valid"}, 64'(valid), 64'(ev));
    check({tag, ".full"},  64'(full),  64'(ef));
    check({tag, ".ovf"},   64'(ovf),   64'(movf));
  endtask

  task automatic step(input string tag, input logic r, input logic [NI-1:0] pu,
                      input logic [NI-1:0] po, input logic [NI*DW-1:0] d);
    @(negedge clk);
    if (po[2] && valid[2]) seen.push_back(r_out[2*DW +: DW]);
    rst = r; push = pu; pop = po; data_in = d;
    @(posedge clk);
    model_edge(r, pu, po, d);
    #1;
    compare_all(tag);
  endtask

  initial begin
    logic [NI*DW-1:0] d;
    rst = 1'b0; push = '0; pop = '0; data_in = '0; movf = '0;

    // Reset held with pushes asserted
    for (int k = 0; k < 3; k++) step("reset", 1'b0, 4'hF, '0, 64'haaaa_bbbb_cccc_dddd);
    check("reset.r_out_zero", 64'(r_out), 64'h0);

    // Single push then pop on lane 0
    step("push0", 1'b1, 4'b0001, 4'b0000, 64'h0000_0000_0000_dddd);
    check("push0.r_out", 64'(r_out), 64'h0000_0000_0000_dddd);
    check("push0.valid", 64'(valid), 64'h1);
    step("pop0", 1'b1, 4'b0000, 4'b0001, '0);
    check("pop0.r_out", 64'(r_out), 64'h0);

    // Order across pointer wrap on lane 2
    seen.delete();
    for (int k = 1; k <= 6; k++) begin
      d = '0;
      d[2*DW +: DW] = DW'(k);
      step("wrap.push", 1'b1, 4'b0100, (k > 3) ? 4'b0100 : 4'b0000, d);
    end
    for (int k = 0; k < 4; k++) step("wrap.drain", 1'b1, 4'b0000, 4'b0100, '0);
    check("wrap.count", 64'(seen.size()), 64'd6);
    for (int k = 0; k < seen.size(); k++) check("wrap.order", 64'(seen[k]), 64'(k + 1));
    check("wrap.ovf2", 64'(ovf[2]), 64'h0);

    // Full and overflow on lane 1
    for (int k = 0; k < 5; k++) begin
      d = '0;
      d[1*DW +: DW] = DW'(16'h1100 + k);
      step("ovf.push", 1'b1, 4'b0010, 4'b0000, d);
      if (k == 3) check("ovf.full_after4", 64'(full[1]), 64'h1);
    end
    check("ovf.flag", 64'(ovf[1]), 64'h1);
    check("ovf.head", 64'(r_out[1*DW +: DW]), 64'h1100);
    for (int k = 0; k < 5; k++) step("ovf.drain", 1'b1, 4'b0000, 4'b0010, '0);
    check("ovf.sticky", 64'(ovf[1]), 64'h1);

    // Push+pop on a full lane 3, then on empty lane 0
    for (int k = 0; k < 4; k++) begin
      d = '0;
      d[3*DW +: DW] = DW'(16'h3300 + k);
      step("fill3", 1'b1, 4'b1000, 4'b0000, d);
    end
    d = '0;
    d[3*DW +: DW] = 16'h33ff;
    step("pp_full", 1'b1, 4'b1000, 4'b1000, d);
    check("pp_full.full", 64'(full[3]), 64'h1);
    check("pp_full.ovf", 64'(ovf[3]), 64'h0);
    check("pp_full.head", 64'(r_out[3*DW +: DW]), 64'h3301);
    d = '0;
    d[0 +: DW] = 16'h0abc;
    step("pp_empty", 1'b1, 4'b0001, 4'b0001, d);
    check("pp_empty.head", 64'(r_out[0 +: DW]), 64'h0abc);

    // Reset mid-operation with two words per lane
    step("pre_rst", 1'b0, '0, '0, '0);
    step("two_a", 1'b1, 4'hF, '0, 64'h1111_2222_3333_4444);
    step("two_b", 1'b1, 4'hF, '0, 64'h5555_6666_7777_8888);
    step("mid_rst", 1'b0, 4'hF, 4'hF, 64'h9999_9999_9999_9999);
    check("mid_rst.valid", 64'(valid), 64'h0);
    check("mid_rst.r_out", 64'(r_out), 64'h0);
    step("post_rst", 1'b1, 4'b0100, '0, 64'h0000_beef_0000_0000);
    check("post_rst.r_out", 64'(r_out), 64'h0000_beef_0000_0000);

    // Random traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      d = {$urandom(), $urandom()};
      step("rand", ($urandom_range(0, 63) != 0), NI'($urandom()), NI'($urandom()), d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sched_input_queue.md
# sched_input_queue

Per-lane input buffering stage that sits directly upstream of the `scheduler` block. It holds up to `DEPTH` words per input lane in independent show-ahead FIFOs. Its packed head-of-queue bus drives the scheduler's `r_in`, and the scheduler (or its wrapper) returns per-lane pops. Per-lane status (`valid`, `full`, sticky overflow) is exported for flow control and debug.

## Interface
- `DATA_WIDTH`, 16, word width per lane
- `N_INPUTS`, 4, number of lanes; must match the scheduler's `N_INPUTS`
- `DEPTH`, 4, words per lane FIFO; power of two, ≥ 2
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset; sampled on rising `clk`
- `push`  in  N_INPUTS  per-lane write enable
- `data_in`  in  N_INPUTS*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `pop`  in  N_INPUTS  per-lane read acknowledge from the scheduler side
- `r_out`  out  N_INPUTS*DATA_WIDTH  head word of each lane, same packing as `data_in`; connects to scheduler `r_in`
- `valid`  out  N_INPUTS  lane i non-empty
- `full`  out  N_INPUTS  lane i holds `DEPTH` words
- `ovf`  out  N_INPUTS  sticky: a push to lane i was dropped

## Operation
- Each lane is an independent circular buffer:
  - write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo `DEPTH`
  - occupancy count, log2(DEPTH)+1 bits
- Show-ahead behaviour:
  - `r_out` lane i equals the storage entry at the read pointer whenever `valid[i]` = 1
  - it is forced to 0 when the lane is empty
- `valid[i]` = (count ≠ 0); `full[i]` = (count == DEPTH). Both are decoded from registered count, with no combinational path from `push`/`pop`.
- Per-lane update on each rising edge, with `rst` = 1:
  - push only, not full: write word, advance write pointer, count+1
  - push only, full: word dropped, pointers and count unchanged, `ovf[i]` ← 1
  - pop only, non-empty: advance read pointer, count−1
  - pop only, empty: ignored, no state change, no flag
  - push and pop, empty: pop ignored; push performed, count → 1
  - push and pop, full: both performed, count stays `DEPTH`, no overflow
  - push and pop, otherwise: both performed, count unchanged
- `ovf[i]` clears only on reset.
- Lanes never interact; events on different lanes in the same cycle are fully independent.
- Reset (`rst` = 0 at a rising edge), including mid-operation:
  - all pointers and counts → 0; `valid`, `full`, `ovf` → 0; `r_out` → 0
  - buffered words are discarded
  - `push`/`pop` in a reset cycle are ignored
- Storage contents need no reset; they must never be visible through `r_out` while the lane is empty.

## Timing
- Push-to-visible latency is 1 cycle: a word pushed into an empty lane at edge k appears on `r_out` with `valid` = 1 after edge k.
- Pop-to-next-head latency is 1 cycle: after the popping edge, `r_out` shows the next word, or 0 with `valid` = 0.
- `full` rises after the edge that stores the `DEPTH`-th word. It falls after the first pop from full, unless a push occurs in the same cycle.
- `ovf` rises after the edge carrying the dropped push.
- Sustained push+pop every cycle on a non-empty lane gives 1 word/cycle throughput at constant occupancy.
- All outputs are a function of registered state only.

## Structure
- A shared package holds:
  - the lane-slice helper (`i*DATA_WIDTH +: DATA_WIDTH`)
  - the pointer width constant `PTR_W` = $clog2(DEPTH)
  - the count width `CNT_W` = `PTR_W`+1
  - both are common with the scheduler and any downstream stage
- One sub-module, `lane_fifo`:
  - a single show-ahead FIFO with `push`, `din`, `pop`, `dout`, `valid`, `full`, `ovf`
  - the top level instantiates `N_INPUTS` copies in a generate loop and performs only bus packing.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles with `push` = 4'hF and `data_in` = 64'haaaa_bbbb_cccc_dddd -> `valid`, `full`, `ovf` and `r_out` all remain 0.
- Single push: after release, push lane 0 with 16'hdddd for one cycle -> the next cycle shows `r_out` = 64'h0000_0000_0000_dddd and `valid` = 4'b0001. Pop lane 0 -> `r_out` returns to 0 and `valid` to 0.
- Order and wrap: push 16'h0001..16'h0006 into lane 2, popping after the 3rd push -> `r_out` lane 2 yields 1, 2, 3, 4, 5, 6 in order across pointer wrap, and `ovf[2]` stays 0.
- Full and overflow: push 5 words into lane 1 (`DEPTH` = 4) -> `full[1]` is set after the 4th push. The 5th word is dropped and `ovf[1]` = 1 sticks. Draining yields only the first 4 words.
- Simultaneous events:
  - push+pop on a full lane 3 -> `full` stays 1, `ovf[3]` stays 0, and head advances
  - push+pop on an empty lane -> count becomes 1
- Reset mid-operation: with lanes at 2 words each, pull `rst` low for 1 cycle -> all `valid` = 0, `r_out` = 0, and `ovf` cleared. The next push shows its word after 1 cycle with no stale data.
